// File: rtl/cpu_pkg.sv
// Package: cpu_pkg
// Shared definitions for the multi-cycle accumulator CPU.
//   opcode_e     - instruction opcodes; the instruction word is {opcode, operand}
//   state_t      - FSM state type, with the ST_* encodings
//   OP_BITS_DEF  - default opcode field width
package cpu_pkg;

  localparam int OP_BITS_DEF = 4;

  // Encodings 12..15 are unused and execute as NOP.
  typedef enum logic [OP_BITS_DEF-1:0] {
    OP_NOP,
    OP_LOAD,
    OP_STO,
    OP_SUM,
    OP_SUB,
    OP_MULTI,
    OP_DIV,
    OP_JUMP,
    OP_TST,
    OP_IN,
    OP_OUT,
    OP_HALT
  } opcode_e;

  // FSM states are plain constants so older tools and scripts can match them.
  typedef logic [1:0] state_t;
  localparam state_t ST_FETCH  = 2'd0;
  localparam state_t ST_DECODE = 2'd1;
  localparam state_t ST_EXEC   = 2'd2;
  localparam state_t ST_HALT   = 2'd3;

endpackage

// File: rtl/cpu_alu.sv
// Module: cpu_alu
// Combinational datapath for the accumulator CPU.
//   acc     in   DATA_BITS  current accumulator
//   mem     in   DATA_BITS  memory operand (RAM read data)
//   op      in   opcode_e   instruction being executed
//   result  out  DATA_BITS  new accumulator value (LOAD passes mem through)
//   carry   out  1          carry / borrow / overflow / div-by-zero indication
//   div0    out  1          DIV with a zero divisor
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic [DATA_BITS-1:0] acc,
  input  logic [DATA_BITS-1:0] mem,
  input  opcode_e              op,
  output logic [DATA_BITS-1:0] result,
  output logic                 carry,
  output logic                 div0
);

  logic [DATA_BITS:0]     add_w;
  logic [DATA_BITS:0]     sub_w;
  logic [2*DATA_BITS-1:0] prod;

  // One extra bit captures carry-out on add and borrow-out on subtract.
  assign add_w = {1'b0, acc} + {1'b0, mem};
  assign sub_w = {1'b0, acc} - {1'b0, mem};
  assign prod  = {{DATA_BITS{1'b0}}, acc} * {{DATA_BITS{1'b0}}, mem};

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    result = mem;
    carry  = 1'b0;
    div0   = 1'b0;
    case (op)
      OP_SUM:   {carry, result} = add_w;
      OP_SUB:   {carry, result} = sub_w;
      OP_MULTI: begin
        result = prod[DATA_BITS-1:0];
        carry  = |prod[2*DATA_BITS-1:DATA_BITS];
      end
      OP_DIV: begin
        if (mem == '0) begin
          result = '1;
          carry  = 1'b1;
          div0   = 1'b1;
        end else begin
          result = acc / mem;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/accum_cpu_mc.sv
// Module: accum_cpu_mc
// Multi-cycle accumulator CPU: FETCH -> DECODE -> EXEC (CPI 3, IN may stall),
// with a synchronous program ROM and a synchronous data RAM.
//   clock, reset                  single clock; asynchronous active-low reset
//   rom_addr / rom_data           program fetch (data valid one cycle after addr)
//   ram_raddr / ram_rdata         data read (data valid one cycle after addr)
//   ram_we / ram_waddr / ram_wdata  single-cycle write during EXEC of STO
//   in_data / in_valid / in_ready input port handshake (IN instruction)
//   port_out / out_valid          registered output port with 1-cycle strobe
//   halted, err_div0              HALT state and sticky divide-by-zero flag
//   pc_out, cmd_out               debug views of pc and the ir opcode
module accum_cpu_mc
  import cpu_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8,
  parameter int OP_BITS   = OP_BITS_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [ADDR_BITS-1:0]         rom_addr,
  input  logic [OP_BITS+ADDR_BITS-1:0] rom_data,
  output logic [ADDR_BITS-1:0]         ram_raddr,
  input  logic [DATA_BITS-1:0]         ram_rdata,
  output logic                         ram_we,
  output logic [ADDR_BITS-1:0]         ram_waddr,
  output logic [DATA_BITS-1:0]         ram_wdata,
  input  logic [DATA_BITS-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_BITS-1:0]         port_out,
  output logic                         out_valid,
  output logic                         halted,
  output logic                         err_div0,
  output logic [ADDR_BITS-1:0]         pc_out,
  output logic [OP_BITS-1:0]           cmd_out
);

  localparam int IW = OP_BITS + ADDR_BITS;

  state_t               state_q;
  logic [ADDR_BITS-1:0] pc_q;
  logic [IW-1:0]        ir_q;
  logic [DATA_BITS-1:0] acc_q;
  logic                 z_q;
  logic                 c_q;

  opcode_e              op;
  logic [ADDR_BITS-1:0] operand;
  logic [DATA_BITS-1:0] alu_result;
  logic                 alu_carry;
  logic                 alu_div0;

  logic [ADDR_BITS-1:0] pc_nx;
  logic [DATA_BITS-1:0] acc_nx;
  logic                 acc_we;
  logic                 c_nx;
  logic                 exec_fire;

  assign op      = opcode_e'(ir_q[IW-1:ADDR_BITS]);
  assign operand = ir_q[ADDR_BITS-1:0];

  cpu_alu #(.DATA_BITS(DATA_BITS)) u_alu (
    .acc    (acc_q),
    .mem    (ram_rdata),
    .op     (op),
    .result (alu_result),
    .carry  (alu_carry),
    .div0   (alu_div0)
  );

  // Next-state values for an instruction completing in EXEC.
  always_comb begin
    acc_we = 1'b0;
    acc_nx = alu_result;
    pc_nx  = pc_q + ADDR_BITS'(1);
    c_nx   = c_q;
    case (op)
      OP_LOAD: acc_we = 1'b1;
      OP_SUM, OP_SUB, OP_MULTI, OP_DIV: begin
        acc_we = 1'b1;
        c_nx   = alu_carry;
      end
      OP_IN: begin
        acc_we = 1'b1;
        acc_nx = in_data;
      end
      OP_JUMP: pc_nx = operand;
      // z always mirrors acc==0, so it stands in for the zero test.
      OP_TST:  if (z_q) pc_nx = pc_q + ADDR_BITS'(2);
      OP_HALT: pc_nx = pc_q;
      default: ;
    endcase
  end

  // IN is the only instruction that can hold EXEC open.
  assign exec_fire = (state_q == ST_EXEC) && ((op != OP_IN) || in_valid);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      acc_q     <= '0;
      z_q       <= 1'b1;
      c_q       <= 1'b0;
      port_out  <= '0;
      out_valid <= 1'b0;
      err_div0  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        ST_FETCH:  state_q <= ST_DECODE;
        ST_DECODE: begin
          ir_q    <= rom_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (exec_fire) begin
            pc_q <= pc_nx;
            c_q  <= c_nx;
            if (acc_we) begin
              acc_q <= acc_nx;
              z_q   <= (acc_nx == '0);
            end
            if (op == OP_OUT) begin
              port_out  <= acc_q;
              out_valid <= 1'b1;
            end
            if (alu_div0 && (op == OP_DIV)) err_div0 <= 1'b1;
            state_q <= (op == OP_HALT) ? ST_HALT : ST_FETCH;
          end
        end
        ST_HALT: ;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // The RAM read takes a cycle, so the operand is presented straight from
  // rom_data during DECODE; the data is then ready for EXEC. From EXEC on the
  // address comes from ir.
  assign ram_raddr = (state_q == ST_DECODE) ? rom_data[ADDR_BITS-1:0] : operand;

  assign rom_addr  = pc_q;
  assign ram_we    = (state_q == ST_EXEC) && (op == OP_STO);
  assign ram_waddr = operand;
  assign ram_wdata = acc_q;
  assign in_ready  = (state_q == ST_EXEC) && (op == OP_IN);
  assign halted    = (state_q == ST_HALT);
  assign pc_out    = pc_q;
  assign cmd_out   = ir_q[IW-1:ADDR_BITS];

endmodule

// File: tb/tb_accum_cpu_mc.sv
// Testbench: tb_accum_cpu_mc
// Directed and randomized programs for accum_cpu_mc. An instruction-level
// interpreter predicts output-port values, halt address, err_div0 and final
// RAM contents; a few cycle-level checks cover timing, stalls and reset.
module tb_accum_cpu_mc;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [7:0]  ram_raddr;
  logic [7:0]  ram_rdata;
  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [7:0]  ram_wdata;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  port_out;
  logic        out_valid;
  logic        halted;
  logic        err_div0;
  logic [7:0]  pc_out;
  logic [3:0]  cmd_out;

  accum_cpu_mc dut (
    .clock     (clock),
    .reset     (reset),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .port_out  (port_out),
    .out_valid (out_valid),
    .halted    (halted),
    .err_div0  (err_div0),
    .pc_out    (pc_out),
    .cmd_out   (cmd_out)
  );

  always #5 clock = ~clock;

  // Memories
  logic [11:0] rom      [256];
  logic [7:0]  ram      [256];
  logic [7:0]  ram_init [256];
  logic        ram_load = 1'b0;

  always @(posedge clock) rom_data <= rom[rom_addr];

  always @(posedge clock) begin
    if (ram_load) begin
      ram <= ram_init;
    end else begin
      ram_rdata <= ram[ram_raddr];
      if (ram_we) ram[ram_waddr] <= ram_wdata;
    end
  end

  // Input-port driver: values from in_vals in order; in_valid held low for the
  // first min_stall cycles of each IN, then raised always or at random.
  logic [7:0] in_vals [64];
  int         min_stall   = 0;
  bit         force_valid = 1'b0;
  int         rdy_cnt;
  int         in_idx;
  bit         xfer;

  always @(negedge clock) begin
    if (!reset) begin
      in_valid = 1'b0;
      in_idx   = 0;
      rdy_cnt  = 0;
      xfer     = 1'b0;
    end else begin
      if (xfer) begin
        in_idx++;
        rdy_cnt = 0;
      end
      if (in_ready) begin
        in_valid = (rdy_cnt >= min_stall) && (force_valid || $urandom_range(0, 1) == 1);
        rdy_cnt++;
      end else begin
        in_valid = 1'b0;
      end
      xfer = in_valid && in_ready;
    end
    in_data = in_vals[in_idx % 64];
  end

  // Output-port monitor
  logic [7:0] got_outs[$];
  bit         prev_ov;
  int         pulse_err;

  always @(negedge clock) begin
    if (!reset) begin
      got_outs.delete();
      prev_ov   = 1'b0;
      pulse_err = 0;
    end else begin
      if (out_valid) begin
        got_outs.push_back(port_out);
        if (prev_ov) pulse_err++;
      end
      prev_ov = out_valid;
    end
  end

  // Checking
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one instruction per step, plain integer arithmetic.
  logic [7:0] m_ram [256];
  logic [7:0] exp_outs[$];
  int         exp_pc;
  bit         exp_div0;
  bit         exp_halted;

  task automatic model_run();
    int pc, nxt, acc, mem, idx, opd;
    logic [11:0] w;
    pc = 0; acc = 0; idx = 0;
    exp_div0 = 1'b0; exp_halted = 1'b0;
    exp_outs.delete();
    for (int i = 0; i < 256; i++) m_ram[i] = ram_init[i];
    for (int step = 0; step < 1000 && !exp_halted; step++) begin
      w   = rom[pc];
      opd = int'(w[7:0]);
      mem = int'(m_ram[opd]);
      nxt = (pc + 1) % 256;
      case (w[11:8])
        OP_LOAD:  acc = mem;
        OP_STO:   m_ram[opd] = 8'(acc);
        OP_SUM:   acc = (acc + mem) % 256;
        OP_SUB:   acc = (acc - mem + 256) % 256;
        OP_MULTI: acc = (acc * mem) % 256;
        OP_DIV: begin
          if (mem == 0) begin
            acc = 255;
            exp_div0 = 1'b1;
          end else begin
            acc = acc / mem;
          end
        end
        OP_JUMP:  nxt = opd;
        OP_TST:   if (acc == 0) nxt = (pc + 2) % 256;
        OP_IN: begin
          acc = int'(in_vals[idx % 64]);
          idx++;
        end
        OP_OUT:   exp_outs.push_back(8'(acc));
        OP_HALT: begin
          exp_halted = 1'b1;
          nxt = pc;
        end
        default: ;
      endcase
      pc = nxt;
    end
    exp_pc = pc;
  endtask

  function automatic logic [11:0] ins(input opcode_e op, input logic [7:0] a);
    return {op, a};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i]      = ins(OP_NOP, 8'h00);
      ram_init[i] = 8'h00;
    end
    for (int i = 0; i < 64; i++) in_vals[i] = 8'h00;
    min_stall   = 0;
    force_valid = 1'b1;
  endtask

  // Hold reset, run the model, load RAM. Caller releases reset.
  task automatic prog_load();
    reset = 1'b0;
    model_run();
    ram_load = 1'b1;
    repeat (2) @(negedge clock);
    ram_load = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_rst(input string name);
    check({name, "/pc"},        pc_out,    0);
    check({name, "/rom_addr"},  rom_addr,  0);
    check({name, "/cmd"},       cmd_out,   0);
    check({name, "/port_out"},  port_out,  0);
    check({name, "/out_valid"}, out_valid, 0);
    check({name, "/ram_we"},    ram_we,    0);
    check({name, "/in_ready"},  in_ready,  0);
    check({name, "/halted"},    halted,    0);
    check({name, "/err_div0"},  err_div0,  0);
  endtask

  task automatic prog_finish(input string name, input int budget);
    int cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check({name, "/halted"},   halted,    exp_halted);
    check({name, "/halt_pc"},  pc_out,    exp_pc);
    check({name, "/rom_addr"}, rom_addr,  exp_pc);
    check({name, "/cmd"},      cmd_out,   OP_HALT);
    check({name, "/ram_we"},   ram_we,    0);
    check({name, "/err_div0"}, err_div0,  exp_div0);
    check({name, "/pulse"},    pulse_err, 0);
    check({name, "/n_outs"},   got_outs.size(), exp_outs.size());
    for (int i = 0; i < exp_outs.size() && i < got_outs.size(); i++)
      check($sformatf("%s/out%0d", name, i), got_outs[i], exp_outs[i]);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s/ram%0d", name, i), ram[i], m_ram[i]);
  endtask

  task automatic gen_random();
    logic [3:0] opc;
    logic [7:0] a;
    clear_mem();
    force_valid = 1'b0;
    for (int i = 0; i < 64; i++) in_vals[i] = 8'($urandom);
    for (int i = 0; i < 16; i++)
      ram_init[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 15));
      case ($urandom_range(0, 13))
        0:       opc = OP_NOP;
        1, 11:   opc = OP_LOAD;
        2:       opc = OP_STO;
        3, 12:   opc = OP_SUM;
        4:       opc = OP_SUB;
        5:       opc = OP_MULTI;
        6:       opc = OP_DIV;
        7:       opc = OP_TST;
        8:       opc = OP_IN;
        9:       opc = OP_OUT;
        10: begin
          opc = OP_JUMP;
          a   = 8'($urandom_range(i + 1, 26));
        end
        default: opc = 4'($urandom_range(12, 15));
      endcase
      rom[i] = {opc, a};
    end
    rom[24] = ins(OP_OUT, 8'h00);
    for (int i = 25; i < 28; i++) rom[i] = ins(OP_HALT, 8'h00);
  endtask

  initial begin
    int cyc;

    // A: LOAD 5; SUM 3; OUT -> 12 exactly 9 cycles after reset release
    clear_mem();
    rom[0] = ins(OP_LOAD, 8'd5);
    rom[1] = ins(OP_SUM,  8'd3);
    rom[2] = ins(OP_OUT,  8'd0);
    rom[3] = ins(OP_HALT, 8'd0);
    ram_init[5] = 8'd5;
    ram_init[3] = 8'd7;
    prog_load();
    check_rst("reset");
    reset = 1'b1;
    repeat (8) @(negedge clock);
    check("A/ov_cyc8", out_valid, 0);
    @(negedge clock);
    check("A/ov_cyc9", out_valid, 1);
    check("A/port_cyc9", port_out, 8'd12);
    @(negedge clock);
    check("A/ov_cyc10", out_valid, 0);
    check("A/port_hold", port_out, 8'd12);
    prog_finish("A", 200);

    // SUB borrow and TST in both directions
    clear_mem();
    rom[0] = ins(OP_LOAD, 8'd1);
    rom[1] = ins(OP_SUB,  8'd2);
    rom[2] = ins(OP_OUT,  8'd0);
    rom[3] = ins(OP_TST,  8'd0);
    rom[4] = ins(OP_OUT,  8'd0);
    rom[5] = ins(OP_LOAD, 8'd3);
    rom[6] = ins(OP_TST,  8'd0);
    rom[7] = ins(OP_OUT,  8'd0);
    rom[8] = ins(OP_HALT, 8'd0);
    ram_init[1] = 8'd2;
    ram_init[2] = 8'd3;
    prog_load();
    reset = 1'b1;
    prog_finish("SUBTST", 200);

    // JUMP to 0xFF, NOP wraps pc to 0x00
    clear_mem();
    rom[0]     = ins(OP_LOAD, 8'd10);
    rom[1]     = ins(OP_TST,  8'd0);
    rom[2]     = ins(OP_HALT, 8'd0);
    rom[3]     = ins(OP_LOAD, 8'd11);
    rom[4]     = ins(OP_STO,  8'd10);
    rom[5]     = ins(OP_OUT,  8'd0);
    rom[6]     = ins(OP_JUMP, 8'hFF);
    rom[8'hFF] = ins(OP_NOP,  8'd0);
    ram_init[11] = 8'd1;
    prog_load();
    reset = 1'b1;
    prog_finish("WRAP1", 300);

    // TST at 0xFF with acc=0 wraps to 0x01
    clear_mem();
    rom[0]     = ins(OP_JUMP, 8'h10);
    rom[1]     = ins(OP_HALT, 8'd0);
    rom[8'h10] = ins(OP_LOAD, 8'd12);
    rom[8'h11] = ins(OP_OUT,  8'd0);
    rom[8'h12] = ins(OP_JUMP, 8'hFF);
    rom[8'hFF] = ins(OP_TST,  8'd0);
    prog_load();
    reset = 1'b1;
    prog_finish("WRAP2", 300);

    // DIV by zero (sticky through SUM), then 20/6
    clear_mem();
    rom[0] = ins(OP_LOAD, 8'd1);
    rom[1] = ins(OP_DIV,  8'd2);
    rom[2] = ins(OP_OUT,  8'd0);
    rom[3] = ins(OP_SUM,  8'd3);
    rom[4] = ins(OP_OUT,  8'd0);
    rom[5] = ins(OP_LOAD, 8'd1);
    rom[6] = ins(OP_DIV,  8'd4);
    rom[7] = ins(OP_OUT,  8'd0);
    rom[8] = ins(OP_HALT, 8'd0);
    ram_init[1] = 8'd20;
    ram_init[3] = 8'd1;
    ram_init[4] = 8'd6;
    prog_load();
    reset = 1'b1;
    prog_finish("DIV", 300);
    // Reset while halted with err_div0 set
    reset = 1'b0;
    #1;
    check_rst("halt_rst");

    // IN stalls 5 cycles with pc held, then takes 0xA5
    clear_mem();
    rom[0] = ins(OP_IN,   8'd0);
    rom[1] = ins(OP_OUT,  8'd0);
    rom[2] = ins(OP_HALT, 8'd0);
    in_vals[0] = 8'hA5;
    min_stall  = 5;
    prog_load();
    reset = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("IN/ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("IN/stall%0d", i), {in_ready, pc_out}, {1'b1, 8'h00});
    end
    prog_finish("IN", 200);

    // Reset asserted during EXEC of STO
    clear_mem();
    rom[0] = ins(OP_LOAD, 8'd1);
    rom[1] = ins(OP_STO,  8'd2);
    rom[2] = ins(OP_HALT, 8'd0);
    ram_init[1] = 8'h3C;
    ram_init[2] = 8'h11;
    prog_load();
    reset = 1'b1;
    cyc = 0;
    while (!ram_we && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("STO/we", ram_we, 1);
    check("STO/waddr", ram_waddr, 8'd2);
    check("STO/wdata", ram_wdata, 8'h3C);
    reset = 1'b0;
    #1;
    check_rst("sto_rst");
    repeat (2) @(negedge clock);
    check("STO/no_write", ram[2], 8'h11);

    // Random programs
    for (int r = 0; r < 10; r++) begin
      gen_random();
      prog_load();
      reset = 1'b1;
      prog_finish($sformatf("RND%0d", r), 2000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
